// File: rtl/dmem_io_multi_if.sv
// ----------------------------------------------------------------------------
// dmem_io_multi_if
//   MEM-stage data bus between the PMIPS pipeline and dmem_io_multi.
//
//   Signals
//     addr   16  word address                      (master -> slave)
//     wdata  16  write data                        (master -> slave)
//     write   1  write enable, sampled at clock    (master -> slave)
//     read    1  read enable, qualifies side effects (master -> slave)
//     rdata  16  read data, combinational from addr (slave -> master)
// ----------------------------------------------------------------------------
interface dmem_io_multi_if;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        write;
    logic        read;
    logic [15:0] rdata;

    modport master (
        output addr,
        output wdata,
        output write,
        output read,
        input  rdata
    );

    modport slave (
        input  addr,
        input  wdata,
        input  write,
        input  read,
        output rdata
    );
endinterface

// File: rtl/dmem_io_multi.sv
// ----------------------------------------------------------------------------
// dmem_io_multi
//   Data memory plus memory-mapped I/O for the PMIPS pipeline. Word-addressed
//   RAM, NUM_DISP 7-segment hex-digit registers, NUM_SW synchronised and
//   debounced switches with sticky read-to-clear rising-edge flags.
//
//   Address map (word addresses)
//     0 .. DEPTH-1        RAM
//     IO_BASE + i         DISP[i], i < NUM_DISP (low nibble kept)
//     IO_BASE + 8         SWSTAT, debounced switch levels (read-only)
//     IO_BASE + 9         SWEDGE, rising-edge flags, cleared by a read
//     IO_BASE + 10        IRQMASK (only with DMEM_IO_IRQ_EN)
//   Anything else reads 0 and ignores writes.
//
//   Ports
//     clock    in   rising-edge clock
//     reset    in   synchronous, active-high
//     bus      slave modport of dmem_io_multi_if (addr/wdata/write/read/rdata)
//     sw       in   NUM_SW raw asynchronous switches
//     display  out  7*NUM_DISP, digit i on [7i+6:7i], segments gfedcba
//     irq      out  |(flags & mask), registered (only with DMEM_IO_IRQ_EN)
//
//   Configuration macro
//     DMEM_IO_IRQ_EN  adds the IRQMASK register and the irq output.
// ----------------------------------------------------------------------------
module dmem_io_multi #(
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned NUM_SW   = 2,
    parameter int unsigned NUM_DISP = 1,
    parameter int unsigned DEBOUNCE = 4,
    parameter logic [15:0] IO_BASE  = 16'hFFF0
) (
    input  logic                  clock,
    input  logic                  reset,
    dmem_io_multi_if.slave        bus,
    input  logic [NUM_SW-1:0]     sw,
    output logic [7*NUM_DISP-1:0] display
`ifdef DMEM_IO_IRQ_EN
    ,
    output logic                  irq
`endif
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEBOUNCE + 1);

    localparam logic [15:0] A_SWSTAT  = IO_BASE + 16'd8;
    localparam logic [15:0] A_SWEDGE  = IO_BASE + 16'd9;
`ifdef DMEM_IO_IRQ_EN
    localparam logic [15:0] A_IRQMASK = IO_BASE + 16'd10;
`endif

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [15:0]       r_mem  [DEPTH];
    logic [3:0]        r_disp [NUM_DISP];

    logic [NUM_SW-1:0] r_sync1;
    logic [NUM_SW-1:0] r_sync2;
    logic [NUM_SW-1:0] r_deb;
    logic [CW-1:0]     r_cnt  [NUM_SW];
    logic [NUM_SW-1:0] r_flag;

`ifdef DMEM_IO_IRQ_EN
    logic [NUM_SW-1:0] r_mask;
    logic              r_irq;
`endif

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic        w_ram_sel;
    logic        w_io;
    logic [15:0] w_off;
    logic        w_swedge_clr;

    assign w_ram_sel    = (32'(bus.addr) < DEPTH);
    assign w_io         = (bus.addr >= IO_BASE);
    assign w_off        = bus.addr - IO_BASE;
    assign w_swedge_clr = bus.read && (bus.addr == A_SWEDGE);

    // ------------------------------------------------------------------
    // Debounce acceptance: a channel whose synchronised level has differed
    // from the debounced level for DEBOUNCE consecutive cycles flips now.
    // w_rise marks the channels whose debounced level goes 0->1 this edge.
    // ------------------------------------------------------------------
    logic [NUM_SW-1:0] w_accept;
    logic [NUM_SW-1:0] w_rise;

    always_comb begin
        w_accept = '0;
        for (int unsigned k = 0; k < NUM_SW; k++) begin
            w_accept[k] = (r_sync2[k] != r_deb[k]) &&
                          (r_cnt[k] == CW'(DEBOUNCE - 1));
        end
        w_rise = w_accept & r_sync2 & ~r_deb;
    end

    // ------------------------------------------------------------------
    // Hex decoder, segments gfedcba, active-high
    // ------------------------------------------------------------------
    function automatic logic [6:0] f_hex7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    always_comb begin
        display = '0;
        for (int unsigned i = 0; i < NUM_DISP; i++) begin
            display[7*i +: 7] = f_hex7(r_disp[i]);
        end
    end

    // ------------------------------------------------------------------
    // RAM (no reset on contents)
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (bus.write && w_ram_sel) begin
            r_mem[bus.addr[AW-1:0]] <= bus.wdata;
        end
    end

    // ------------------------------------------------------------------
    // Switch synchroniser, debounce counters and edge flags
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            r_flag  <= '0;
            for (int unsigned k = 0; k < NUM_SW; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            r_sync1 <= sw;
            r_sync2 <= r_sync1;
            for (int unsigned k = 0; k < NUM_SW; k++) begin
                if (r_sync2[k] == r_deb[k]) begin
                    r_cnt[k] <= '0;
                end else if (w_accept[k]) begin
                    r_deb[k] <= r_sync2[k];
                    r_cnt[k] <= '0;
                end else begin
                    r_cnt[k] <= r_cnt[k] + CW'(1);
                end
            end
            // A new rising edge in the same cycle as a clearing read survives.
            r_flag <= (w_swedge_clr ? '0 : r_flag) | w_rise;
        end
    end

    // ------------------------------------------------------------------
    // Display digits (and optional IRQ mask / registered irq)
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_DISP; i++) begin
                r_disp[i] <= '0;
            end
`ifdef DMEM_IO_IRQ_EN
            r_mask <= '0;
            r_irq  <= 1'b0;
`endif
        end else begin
            for (int unsigned i = 0; i < NUM_DISP; i++) begin
                if (bus.write && w_io && (w_off == 16'(i))) begin
                    r_disp[i] <= bus.wdata[3:0];
                end
            end
`ifdef DMEM_IO_IRQ_EN
            if (bus.write && (bus.addr == A_IRQMASK)) begin
                r_mask <= bus.wdata[NUM_SW-1:0];
            end
            r_irq <= |(r_flag & r_mask);
`endif
        end
    end

`ifdef DMEM_IO_IRQ_EN
    assign irq = r_irq;
`endif

    // ------------------------------------------------------------------
    // Combinational read mux
    // ------------------------------------------------------------------
    always_comb begin
        bus.rdata = '0;
        if (w_ram_sel) begin
            bus.rdata = r_mem[bus.addr[AW-1:0]];
        end else if (w_io) begin
            for (int unsigned i = 0; i < NUM_DISP; i++) begin
                if (w_off == 16'(i)) begin
                    bus.rdata = {12'b0, r_disp[i]};
                end
            end
            if (bus.addr == A_SWSTAT) begin
                bus.rdata = 16'(r_deb);
            end
            if (bus.addr == A_SWEDGE) begin
                bus.rdata = 16'(r_flag);
            end
`ifdef DMEM_IO_IRQ_EN
            if (bus.addr == A_IRQMASK) begin
                bus.rdata = 16'(r_mask);
            end
`endif
        end
    end

endmodule

// File: tb/tb_dmem_io_multi.sv
// ----------------------------------------------------------------------------
// tb_dmem_io_multi
//   Directed scenarios followed by randomized bus/switch traffic. A reference
//   model (RAM as an associative array, switches debounced by a sliding window
//   of recent synchronised samples) predicts rdata, display and irq.
// ----------------------------------------------------------------------------
module tb_dmem_io_multi;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned NSW   = 2;
    localparam int unsigned NDISP = 2;
    localparam int unsigned DEB   = 4;
    localparam logic [15:0] IOB   = 16'hFFF0;

    logic               clock = 1'b0;
    logic               reset;
    logic [NSW-1:0]     sw;
    logic [7*NDISP-1:0] display;
`ifdef DMEM_IO_IRQ_EN
    logic               irq;
`endif

    dmem_io_multi_if bus ();

    dmem_io_multi #(
        .DEPTH    (DEPTH),
        .NUM_SW   (NSW),
        .NUM_DISP (NDISP),
        .DEBOUNCE (DEB),
        .IO_BASE  (IOB)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus),
        .sw      (sw),
        .display (display)
`ifdef DMEM_IO_IRQ_EN
        ,
        .irq     (irq)
`endif
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [6:0]  HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [15:0]    m_mem [int];
    logic [3:0]     m_disp [NDISP];
    logic [NSW-1:0] m_q1, m_q2, m_deb, m_flag, m_mask;
    logic           m_irq;
    logic [NSW-1:0] m_h [$];
    bit             m_ok = 0;

    function automatic bit m_read(input logic [15:0] a, output logic [15:0] d);
        d = '0;
        if (int'(a) < int'(DEPTH)) begin
            if (!m_mem.exists(int'(a))) return 0;
            d = m_mem[int'(a)];
        end else if (a >= IOB && int'(a - IOB) < int'(NDISP)) begin
            d = {12'b0, m_disp[int'(a - IOB)]};
        end else if (a == IOB + 16'd8) begin
            d = 16'(m_deb);
        end else if (a == IOB + 16'd9) begin
            d = 16'(m_flag);
`ifdef DMEM_IO_IRQ_EN
        end else if (a == IOB + 16'd10) begin
            d = 16'(m_mask);
`endif
        end
        return 1;
    endfunction

    function automatic logic [7*NDISP-1:0] m_disp_vec();
        logic [7*NDISP-1:0] v;
        for (int i = 0; i < int'(NDISP); i++) v[7*i +: 7] = HEX[m_disp[i]];
        return v;
    endfunction

    // Applies one rising edge to the model using the currently driven inputs.
    task automatic model_edge();
        logic [NSW-1:0] deb_o, flag_o, mask_o, rise;
        bit             all;
        if (reset) begin
            m_q1 = '0; m_q2 = '0; m_deb = '0; m_flag = '0; m_mask = '0; m_irq = 0;
            for (int i = 0; i < int'(NDISP); i++) m_disp[i] = '0;
            m_h.delete();
            m_ok = 1;
            return;
        end
        deb_o = m_deb; flag_o = m_flag; mask_o = m_mask;
        m_h.push_back(m_q2);
        if (m_h.size() > int'(DEB)) void'(m_h.pop_front());
        // Debounced level follows a channel once its last DEB samples all disagree with it.
        for (int k = 0; k < int'(NSW); k++) begin
            if (m_h.size() == int'(DEB)) begin
                all = 1;
                for (int j = 0; j < int'(DEB); j++) if (m_h[j][k] == deb_o[k]) all = 0;
                if (all) m_deb[k] = ~deb_o[k];
            end
        end
        rise   = m_deb & ~deb_o;
        m_flag = ((bus.read && bus.addr == IOB + 16'd9) ? '0 : flag_o) | rise;
`ifdef DMEM_IO_IRQ_EN
        m_irq = |(flag_o & mask_o);
        if (bus.write && bus.addr == IOB + 16'd10) m_mask = bus.wdata[NSW-1:0];
`endif
        if (bus.write) begin
            if (int'(bus.addr) < int'(DEPTH)) m_mem[int'(bus.addr)] = bus.wdata;
            else if (bus.addr >= IOB && int'(bus.addr - IOB) < int'(NDISP))
                m_disp[int'(bus.addr - IOB)] = bus.wdata[3:0];
        end
        m_q2 = m_q1;
        m_q1 = sw;
    endtask

    // ------------------------------------------------------------------
    // Stimulus helpers (entered and left on the falling edge)
    // ------------------------------------------------------------------
    task automatic step(input logic [15:0] a, input logic [15:0] d, input logic w, input logic r);
        logic [15:0] e;
        bit          kn;
        bus.addr = a; bus.wdata = d; bus.write = w; bus.read = r;
        #1;
        if (m_ok) begin
            kn = m_read(a, e);
            if (kn) check("rdata", 32'(bus.rdata), 32'(e));
            check("display", 32'(display), 32'(m_disp_vec()));
`ifdef DMEM_IO_IRQ_EN
            check("irq", 32'(irq), 32'(m_irq));
`endif
        end
        @(posedge clock);
        model_edge();
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(16'h0000, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic peek(input logic [15:0] a, output logic [15:0] d);
        bus.addr = a; bus.write = 1'b0; bus.read = 1'b0;
        #1;
        d = bus.rdata;
    endtask

    logic [15:0] v;
    logic [15:0] ra, rd;
    logic        rw, rr;
    int unsigned pick, b;

    initial begin
        bus.addr = '0; bus.wdata = '0; bus.write = 1'b0; bus.read = 1'b0;
        sw = '0;
        reset = 1'b1;
        @(negedge clock);
        idle(3);
        reset = 1'b0;

        // Reset state
        peek(IOB, v);            check("disp0_reset", 32'(v), 32'h0);
        check("display_reset", 32'(display), 32'h1FBF);
        peek(IOB + 16'd8, v);    check("swstat_reset", 32'(v), 32'h0);
        peek(IOB + 16'd9, v);    check("swedge_reset", 32'(v), 32'h0);

        // RAM write/read and out-of-range read
        step(16'd5, 16'h1234, 1'b1, 1'b0);
        peek(16'd5, v);           check("ram5", 32'(v), 32'h1234);
        peek(16'(DEPTH), v);      check("ram_depth_unmapped", 32'(v), 32'h0);

        // Display digit keeps low nibble
        step(IOB, 16'h00A7, 1'b1, 1'b0);
        check("display0_7", 32'(display[6:0]), 32'h07);
        peek(IOB, v);             check("disp0_rd", 32'(v), 32'h0007);

        // Debounce latency 2+DEB
        sw[0] = 1'b1;
        idle(5);
        peek(IOB + 16'd8, v);     check("swstat_before", 32'(v[0]), 32'h0);
        idle(1);
        peek(IOB + 16'd8, v);     check("swstat_after", 32'(v[0]), 32'h1);

        // Short glitch on sw[1] is rejected
        sw[1] = 1'b1; idle(3); sw[1] = 1'b0; idle(8);
        peek(IOB + 16'd8, v);     check("glitch_swstat", 32'(v), 32'h1);
        peek(IOB + 16'd9, v);     check("glitch_swedge", 32'(v), 32'h1);

        // Read-to-clear, and an edge landing in the clearing cycle survives
        step(IOB + 16'd9, 16'h0, 1'b0, 1'b1);
        peek(IOB + 16'd9, v);     check("swedge_cleared", 32'(v), 32'h0);
        sw[1] = 1'b1;
        idle(5);
        step(IOB + 16'd9, 16'h0, 1'b0, 1'b1);
        peek(IOB + 16'd9, v);     check("swedge_setwins", 32'(v), 32'h2);

`ifdef DMEM_IO_IRQ_EN
        step(IOB + 16'd10, 16'h0001, 1'b1, 1'b0);
        sw[0] = 1'b0; idle(6);
        sw[0] = 1'b1; idle(6);
        check("irq_lag", 32'(irq), 32'h0);
        idle(1);
        check("irq_set", 32'(irq), 32'h1);
        step(IOB + 16'd9, 16'h0, 1'b0, 1'b1);
        idle(1);
        check("irq_clr", 32'(irq), 32'h0);
        sw[0] = 1'b0; sw[1] = 1'b0; idle(7);
        sw[0] = 1'b1; idle(8);
        check("irq_pre_reset", 32'(irq), 32'h1);
        reset = 1'b1; idle(1); reset = 1'b0;
        check("irq_reset", 32'(irq), 32'h0);
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            pick = $urandom_range(0, 9);
            if (pick <= 3)       ra = 16'($urandom_range(0, 15));
            else if (pick == 4)  ra = 16'(DEPTH - 1 + $urandom_range(0, 1));
            else if (pick <= 8)  ra = IOB + 16'($urandom_range(0, 11));
            else                 ra = 16'($urandom());
            rd = 16'($urandom());
            rw = ($urandom_range(0, 2) == 0);
            rr = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 7) == 0) begin
                b = $urandom_range(0, NSW - 1);
                sw[b] = ~sw[b];
            end
            reset = ($urandom_range(0, 199) == 0);
            if (reset) rw = 1'b0;
            step(ra, rd, rw, rr);
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
